// File: rtl/fft1024_frame_io.sv
// Frame I/O wrapper for fft1024: bit-reversed load into the fft0/fft1 banks, engine
// start/finish handshake, and a credit-limited natural-order drain into a valid/ready stream.
module fft1024_frame_io #(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_re,
  input  logic [15:0] in_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_re,
  output logic [15:0] out_im,
  output logic        out_last,
  output logic        fft_start,
  input  logic        fft_finish,
  output logic        mem_sel,
  output logic        ce0,
  output logic        oce0,
  output logic        wre0,
  output logic [10:0] ad0,
  output logic [31:0] din0,
  input  logic [31:0] dout0,
  output logic        ce1,
  output logic        oce1,
  output logic        wre1,
  output logic [10:0] ad1,
  output logic [31:0] din1,
  input  logic [31:0] dout1
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  function automatic logic [9:0] bitrev10(input logic [9:0] v);
    logic [9:0] r;
    for (int b = 0; b < 10; b++) r[b] = v[9 - b];
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  state_t             state_r;
  logic [9:0]         s_cnt_r;
  logic [10:0]        rd_cnt_r;
  logic [9:0]         pop_cnt_r;
  logic               settle_r;
  logic               fin_prev_r;
  logic               in_ready_r;
  logic               fft_start_r;
  logic               mem_sel_r;
  logic               ce0_r, oce0_r, wre0_r, ce1_r, oce1_r, wre1_r;
  logic [10:0]        ad0_r, ad1_r;
  logic [31:0]        din0_r, din1_r;

  logic [31:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]      occ_r;
  logic [READ_LATENCY:0] pipe_vld_r;
  logic [READ_LATENCY:0] pipe_bank_r;

  logic [7:0]         inflight_s;
  logic [7:0]         credit_s;
  logic               pop_s;
  logic               push_s;
  logic               issue_s;
  logic               accept_s;
  logic [9:0]         wr_idx_s;
  logic [31:0]        push_data_s;
  logic [31:0]        head_s;

  // Credit accounting: a new read may issue only if it is guaranteed a FIFO slot on return.
  always_comb begin
    inflight_s = 8'd0;
    for (int b = 0; b <= READ_LATENCY; b++) inflight_s = inflight_s + {7'd0, pipe_vld_r[b]};
    pop_s       = (occ_r != {CW{1'b0}}) && out_ready;
    credit_s    = 8'(occ_r) + inflight_s - {7'd0, pop_s};
    issue_s     = (state_r == S_DRAIN) && !rd_cnt_r[10] && (credit_s < 8'(FIFO_DEPTH));
    push_s      = pipe_vld_r[READ_LATENCY];
    push_data_s = pipe_bank_r[READ_LATENCY] ? dout1 : dout0;
    accept_s    = (state_r == S_LOAD) && in_valid && in_ready_r;
    wr_idx_s    = bitrev10(s_cnt_r);
    head_s      = fifo_mem_r[rd_ptr_r];
  end

  // Frame sequencer with registered handshake and bank-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      s_cnt_r     <= 10'd0;
      rd_cnt_r    <= 11'd0;
      pop_cnt_r   <= 10'd0;
      settle_r    <= 1'b0;
      fin_prev_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      fft_start_r <= 1'b0;
      mem_sel_r   <= 1'b0;
      ce0_r <= 1'b0; oce0_r <= 1'b0; wre0_r <= 1'b0; ad0_r <= 11'd0; din0_r <= 32'd0;
      ce1_r <= 1'b0; oce1_r <= 1'b0; wre1_r <= 1'b0; ad1_r <= 11'd0; din1_r <= 32'd0;
    end else begin
      fin_prev_r  <= fft_finish;
      fft_start_r <= 1'b0;
      ce0_r <= 1'b0; oce0_r <= 1'b0; wre0_r <= 1'b0; ad0_r <= 11'd0; din0_r <= 32'd0;
      ce1_r <= 1'b0; oce1_r <= 1'b0; wre1_r <= 1'b0; ad1_r <= 11'd0; din1_r <= 32'd0;
      case (state_r)
        S_IDLE: begin
          state_r    <= S_LOAD;
          in_ready_r <= 1'b1;
          s_cnt_r    <= 10'd0;
        end
        S_LOAD: begin
          if (accept_s) begin
            if (wr_idx_s[9]) begin
              ce1_r <= 1'b1; wre1_r <= 1'b1;
              ad1_r <= {2'b00, wr_idx_s[8:0]}; din1_r <= {in_re, in_im};
            end else begin
              ce0_r <= 1'b1; wre0_r <= 1'b1;
              ad0_r <= {2'b00, wr_idx_s[8:0]}; din0_r <= {in_re, in_im};
            end
            if (s_cnt_r == 10'd1023) begin
              in_ready_r <= 1'b0;
              settle_r   <= 1'b0;
              state_r    <= S_SETTLE;
            end else begin
              s_cnt_r <= s_cnt_r + 10'd1;
            end
          end else begin
            s_cnt_r <= s_cnt_r;
          end
        end
        // Two quiet cycles: the last write is on the port, then the bank settles.
        S_SETTLE: begin
          if (settle_r) begin
            state_r     <= S_START;
            fft_start_r <= 1'b1;
            mem_sel_r   <= 1'b1;
          end else begin
            settle_r <= 1'b1;
          end
        end
        S_START: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (fft_finish && !fin_prev_r) begin
            state_r   <= S_DRAIN;
            mem_sel_r <= 1'b0;
            rd_cnt_r  <= 11'd0;
            pop_cnt_r <= 10'd0;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DRAIN: begin
          if (issue_s) begin
            if (rd_cnt_r[9]) begin
              ce1_r <= 1'b1; oce1_r <= 1'b1; ad1_r <= {2'b00, rd_cnt_r[8:0]};
            end else begin
              ce0_r <= 1'b1; oce0_r <= 1'b1; ad0_r <= {2'b00, rd_cnt_r[8:0]};
            end
            rd_cnt_r <= rd_cnt_r + 11'd1;
          end else begin
            rd_cnt_r <= rd_cnt_r;
          end
          if (pop_s) begin
            pop_cnt_r <= pop_cnt_r + 10'd1;
            if (pop_cnt_r == 10'd1023) begin
              state_r    <= S_LOAD;
              in_ready_r <= 1'b1;
              s_cnt_r    <= 10'd0;
            end else begin
              state_r <= S_DRAIN;
            end
          end else begin
            pop_cnt_r <= pop_cnt_r;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Read-return tracking and FIFO pointers; the bank tag rides alongside each read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_r  <= '0;
      pipe_bank_r <= '0;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      occ_r       <= {CW{1'b0}};
    end else begin
      pipe_vld_r  <= {pipe_vld_r[READ_LATENCY-1:0], issue_s};
      pipe_bank_r <= {pipe_bank_r[READ_LATENCY-1:0], rd_cnt_r[9]};
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CW'(1);
        2'b01:   occ_r <= occ_r - CW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the occupancy-gated outputs.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= push_data_s;
  end

  assign in_ready  = in_ready_r;
  assign out_valid = (occ_r != {CW{1'b0}});
  assign out_re    = out_valid ? head_s[31:16] : 16'd0;
  assign out_im    = out_valid ? head_s[15:0]  : 16'd0;
  assign out_last  = out_valid && (pop_cnt_r == 10'd1023);
  assign fft_start = fft_start_r;
  assign mem_sel   = mem_sel_r;
  assign ce0 = ce0_r; assign oce0 = oce0_r; assign wre0 = wre0_r; assign ad0 = ad0_r; assign din0 = din0_r;
  assign ce1 = ce1_r; assign oce1 = oce1_r; assign wre1 = wre1_r; assign ad1 = ad1_r; assign din1 = din1_r;

endmodule
